// File: rtl/sc_product_window_pkg.sv
// sc_product_window_pkg
// Shared definitions for the stochastic product window controller:
//   - FSM state encoding (IDLE / RUN / FINISH)
//   - maximal-length Galois LFSR tap masks for widths 3..16
//   - per-operand LFSR seed function
package sc_product_window_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    // Right-shifting Galois LFSR masks. Each mask corresponds to a primitive
    // polynomial, so the register walks every nonzero value (1..2^w-1) once
    // per period.
    function automatic logic [15:0] lfsr_taps(input int w);
        logic [15:0] taps;
        case (w)
            3:       taps = 16'h0006;
            4:       taps = 16'h000C;
            5:       taps = 16'h0014;
            6:       taps = 16'h0030;
            7:       taps = 16'h0060;
            8:       taps = 16'h00B8;
            9:       taps = 16'h0110;
            10:      taps = 16'h0240;
            11:      taps = 16'h0500;
            12:      taps = 16'h0E08;
            13:      taps = 16'h1C80;
            14:      taps = 16'h3802;
            15:      taps = 16'h6000;
            16:      taps = 16'hD008;
            default: taps = 16'h0000;
        endcase
        return taps;
    endfunction

    // Seed for operand k: ((k * step) mod M) + 1, always in 1..M so the
    // LFSR never starts in the all-zero lock-up state.
    function automatic logic [15:0] seed_of(input int k, input int step, input int w);
        int m;
        m = (1 << w) - 1;
        return 16'(((k * step) % m) + 1);
    endfunction

endpackage

// File: rtl/M_AND.sv
// M_AND
// Enabled N-input AND gate used as the stochastic product gate.
// Ports:
//   A  [N-1:0] input bitstream bits
//   EN         gate enable; output is forced low when EN=0
//   Y          AND of all inputs, qualified by EN
module M_AND #(
    parameter int N = 3
) (
    input  logic [N-1:0] A,
    input  logic         EN,
    output logic         Y
);

    assign Y = EN & (&A);

endmodule

// File: rtl/sc_product_window_lfsr.sv
// sc_lfsr
// Maximal-length Galois LFSR producing pseudo-random values in 1..2^W-1.
// Ports:
//   CLK   clock
//   RST   synchronous active-high reset; reloads SEED
//   LOAD  reload SEED (takes priority over STEP)
//   STEP  advance one state
//   R     current register value
module sc_lfsr
    import sc_product_window_pkg::*;
#(
    parameter int           W    = 8,
    parameter logic [W-1:0] SEED = W'(1)
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         LOAD,
    input  logic         STEP,
    output logic [W-1:0] R
);

    localparam logic [W-1:0] TAPS = W'(lfsr_taps(W));

    logic [W-1:0] r_reg;
    logic [W-1:0] r_next;
    logic [W-1:0] shifted;

    assign shifted = {1'b0, r_reg[W-1:1]};
    assign r_next  = r_reg[0] ? (shifted ^ TAPS) : shifted;

    always_ff @(posedge CLK) begin
        if (RST || LOAD) begin
            r_reg <= SEED;
        end else if (STEP) begin
            r_reg <= r_next;
        end
    end

    assign R = r_reg;

endmodule

// File: rtl/sc_product_window.sv
// sc_product_window
// Runs one LFSR period of the stochastic product of N operands and returns
// the ones count as a W-bit binary estimate of the product.
// Ports:
//   CLK     clock
//   RST     synchronous active-high reset
//   START   start request, accepted only in IDLE
//   X       N packed W-bit operands, operand k at [k*W +: W]
//   BUSY    high while the window is running
//   DONE    one-cycle pulse when Y is updated
//   Y       ones count of the last completed window
//   STREAM  registered product-gate output (debug)
module sc_product_window
    import sc_product_window_pkg::*;
#(
    parameter int N         = 3,
    parameter int W         = 8,
    parameter int SEED_STEP = 37
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           START,
    input  logic [N*W-1:0] X,
    output logic           BUSY,
    output logic           DONE,
    output logic [W-1:0]   Y,
    output logic           STREAM
);

    // Cycle count at the start of the last RUN cycle (M-1).
    localparam logic [W-1:0] LAST_CYCLE = {{(W-1){1'b1}}, 1'b0};

    state_t         state_reg, state_next;
    logic [N*W-1:0] x_reg;
    logic [W-1:0]   ones_reg;
    logic [W-1:0]   cycle_reg;
    logic [W-1:0]   y_reg;
    logic           stream_reg;

    logic           load;
    logic           run;
    logic           last;
    logic           gate;
    logic [N-1:0]   bits;
    logic [W-1:0]   r [N];

    assign run  = (state_reg == RUN);
    assign last = run && (cycle_reg == LAST_CYCLE);

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (START) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cycle_reg == LAST_CYCLE) begin
                    state_next = FINISH;
                end
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_operand
            sc_lfsr #(
                .W    (W),
                .SEED (W'(seed_of(gi, SEED_STEP, W)))
            ) u_lfsr (
                .CLK  (CLK),
                .RST  (RST),
                .LOAD (load),
                .STEP (run),
                .R    (r[gi])
            );

            // R ranges over 1..M, so R <= x is true for exactly x values
            // per period: the stream density is x/M.
            assign bits[gi] = (r[gi] <= x_reg[gi*W +: W]);
        end
    endgenerate

    M_AND #(
        .N (N)
    ) u_and (
        .A  (bits),
        .EN (run),
        .Y  (gate)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg  <= IDLE;
            x_reg      <= '0;
            ones_reg   <= '0;
            cycle_reg  <= '0;
            y_reg      <= '0;
            stream_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            stream_reg <= gate;
            if (load) begin
                x_reg     <= X;
                ones_reg  <= '0;
                cycle_reg <= '0;
            end else if (run) begin
                ones_reg  <= ones_reg + W'(gate);
                cycle_reg <= cycle_reg + 1'b1;
            end
            // Include the final evaluation so Y is already valid during
            // the FINISH cycle alongside DONE.
            if (last) begin
                y_reg <= ones_reg + W'(gate);
            end
        end
    end

    assign BUSY   = run;
    assign DONE   = (state_reg == FINISH);
    assign Y      = y_reg;
    assign STREAM = stream_reg;

endmodule

// File: tb/tb_sc_product_window.sv
// Testbench for sc_product_window: one N=1 and one N=3 instance (W=8),
// table-driven windows plus hand-written reset/idle sequences.
module tb_sc_product_window;

    logic        clk = 1'b0;
    logic        rst;
    logic        start1, start3;
    logic [7:0]  x1;
    logic [23:0] x3;
    logic        busy1, done1, stream1;
    logic        busy3, done3, stream3;
    logic [7:0]  y1, y3;

    int compared   = 0;
    int mismatched = 0;
    logic [7:0] prev_y1 = 8'd0;
    logic [7:0] prev_y3 = 8'd0;

    always #5 clk = ~clk;

    sc_product_window #(.N(1), .W(8), .SEED_STEP(37)) dut1 (
        .CLK(clk), .RST(rst), .START(start1), .X(x1),
        .BUSY(busy1), .DONE(done1), .Y(y1), .STREAM(stream1)
    );

    sc_product_window #(.N(3), .W(8), .SEED_STEP(37)) dut3 (
        .CLK(clk), .RST(rst), .START(start3), .X(x3),
        .BUSY(busy3), .DONE(done3), .Y(y3), .STREAM(stream3)
    );

    typedef struct {
        bit         sel3;   // 1: N=3 instance, 0: N=1 instance
        logic [7:0] x0, x1, x2;
        int         lo, hi; // accepted Y range
        bit         ign;    // pulse START at RUN cycles 1, 100, 254
        bit         tog;    // toggle X every cycle during RUN
    } vec_t;

    vec_t tab[10];

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        compared++;
        if (act < lo || act > hi) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Start one window on the selected instance and follow it to DONE.
    task automatic run_window(input vec_t v, input int idx);
        int         busy_cnt = 0;
        int         done_at  = -1;
        int         y_moved  = 0;
        bit         stream_seen = 1'b0;
        logic       b, d, s;
        logic [7:0] yy, prev, y_done;
        logic       busy_at_done = 1'b1;
        y_done = 8'd0;
        prev   = v.sel3 ? prev_y3 : prev_y1;

        @(negedge clk);
        if (v.sel3) begin
            x3 = {v.x2, v.x1, v.x0}; start3 = 1'b1;
        end else begin
            x1 = v.x0; start1 = 1'b1;
        end
        @(negedge clk);
        start1 = 1'b0;
        start3 = 1'b0;

        for (int cyc = 1; cyc <= 400; cyc++) begin
            if (v.sel3) begin
                b = busy3; d = done3; yy = y3; s = stream3;
            end else begin
                b = busy1; d = done1; yy = y1; s = stream1;
            end
            if (s) stream_seen = 1'b1;
            if (d) begin
                done_at      = cyc;
                y_done       = yy;
                busy_at_done = b;
                break;
            end
            if (b) busy_cnt++;
            if (yy !== prev) y_moved++;
            @(negedge clk);
            if (v.tog) begin
                x3 = ~x3;
                x1 = ~x1;
            end
            if (v.ign && (cyc == 1 || cyc == 100 || cyc == 254)) begin
                if (v.sel3) start3 = 1'b1; else start1 = 1'b1;
            end else begin
                start1 = 1'b0;
                start3 = 1'b0;
            end
        end

        $display("window %0d: n=%0d x={%0d,%0d,%0d} busy=%0d done_at=%0d y=%0d",
                 idx, v.sel3 ? 3 : 1, v.x2, v.x1, v.x0, busy_cnt, done_at, y_done);
        chk($sformatf("busy_cycles[%0d]", idx), busy_cnt, 255);
        chk($sformatf("done_at[%0d]", idx), done_at, 256);
        chk($sformatf("busy_at_done[%0d]", idx), int'(busy_at_done), 0);
        chk($sformatf("y_held[%0d]", idx), y_moved, 0);
        chk_range($sformatf("y[%0d]", idx), int'(y_done), v.lo, v.hi);
        chk($sformatf("stream_active[%0d]", idx), int'(stream_seen), (v.hi == 0) ? 0 : 1);
        if (v.sel3) prev_y3 = y_done; else prev_y1 = y_done;
    endtask

    initial begin
        tab[0] = '{sel3: 0, x0: 100, x1: 0,   x2: 0,   lo: 100, hi: 100, ign: 0, tog: 0};
        tab[1] = '{sel3: 1, x0: 255, x1: 255, x2: 255, lo: 255, hi: 255, ign: 0, tog: 0};
        tab[2] = '{sel3: 1, x0: 255, x1: 0,   x2: 255, lo: 0,   hi: 0,   ign: 0, tog: 0};
        tab[3] = '{sel3: 1, x0: 128, x1: 128, x2: 128, lo: 20,  hi: 44,  ign: 0, tog: 1};
        tab[4] = '{sel3: 1, x0: 255, x1: 255, x2: 100, lo: 100, hi: 100, ign: 1, tog: 0};
        tab[5] = '{sel3: 1, x0: 1,   x1: 255, x2: 255, lo: 1,   hi: 1,   ign: 0, tog: 0};
        tab[6] = '{sel3: 0, x0: 0,   x1: 0,   x2: 0,   lo: 0,   hi: 0,   ign: 0, tog: 0};
        tab[7] = '{sel3: 0, x0: 255, x1: 0,   x2: 0,   lo: 255, hi: 255, ign: 1, tog: 0};
        tab[8] = '{sel3: 0, x0: 1,   x1: 0,   x2: 0,   lo: 1,   hi: 1,   ign: 0, tog: 1};
        tab[9] = '{sel3: 1, x0: 255, x1: 200, x2: 255, lo: 200, hi: 200, ign: 0, tog: 0};

        rst = 1'b1; start1 = 1'b0; start3 = 1'b0; x1 = 8'd0; x3 = 24'd0;
        // START alongside reset must be ignored.
        @(negedge clk); start3 = 1'b1; start1 = 1'b1;
        @(negedge clk); start3 = 1'b0; start1 = 1'b0;
        @(negedge clk); rst = 1'b0;

        // Idle: nothing moves with START low.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_busy3", int'(busy3), 0);
            chk("idle_done3", int'(done3), 0);
            chk("idle_y3", int'(y3), 0);
            chk("idle_stream3", int'(stream3), 0);
            chk("idle_busy1", int'(busy1), 0);
            chk("idle_y1", int'(y1), 0);
        end
        $display("idle: 20 cycles checked");

        for (int i = 0; i < 10; i++) begin
            run_window(tab[i], i);
        end

        // DONE is a single-cycle pulse.
        @(negedge clk);
        chk("done_pulse_width", int'(done3), 0);
        chk("y_after_done", int'(y3), 200);

        // Reset in the middle of a window.
        @(negedge clk);
        x3 = {8'd255, 8'd255, 8'd255}; start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        begin
            int early_done = 0;
            for (int cyc = 1; cyc < 50; cyc++) begin
                if (done3) early_done++;
                @(negedge clk);
            end
            chk("no_done_before_rst", early_done, 0);
        end
        chk("busy_pre_rst", int'(busy3), 1);
        chk("y_pre_rst", int'(y3), 200);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_busy", int'(busy3), 0);
        chk("rst_y", int'(y3), 0);
        chk("rst_stream", int'(stream3), 0);
        chk("rst_done", int'(done3), 0);
        $display("mid-run reset: busy=%0d y=%0d stream=%0d done=%0d", busy3, y3, stream3, done3);
        rst = 1'b0;
        prev_y1 = 8'd0;
        prev_y3 = 8'd0;
        begin
            vec_t v;
            v = '{sel3: 1, x0: 255, x1: 255, x2: 100, lo: 100, hi: 100, ign: 0, tog: 0};
            run_window(v, 10);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sc_product_window.md
# sc_product_window

Sequencing controller for the stochastic product datapath. On a start request it latches N unsigned binary operands and converts each to a bitstream with a per-operand LFSR comparator. It enables the cascaded-AND product gate for exactly one LFSR period and counts the ones at the gate output. The result is a W-bit binary estimate of the product of the N operand probabilities, used by neuron blocks that need a binary-domain product of stochastic weights/activations.

## Interface
Parameters:
- N, 3, operand count; 1..16.
- W, 8, operand/result width; 3..16. Window length M = 2^W − 1 cycles.
- SEED_STEP, 37, seed spacing between operand LFSRs; must be odd.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset; synchronous, active-high.
- START  in  1  request; sampled only in IDLE.
- X  in  N*W  operands, packed; operand k at [k*W +: W]; value x means probability x/M.
- BUSY  out  1  high while a window is running.
- DONE  out  1  one-cycle pulse when Y is updated.
- Y  out  W  ones count of the last completed window; held until next DONE.
- STREAM  out  1  registered product-gate output, for debug/observation.

## Operation
- States: IDLE, RUN, FINISH.
- IDLE: BUSY=0. START=1 causes these actions, then → RUN:
  - latch X into the operand register;
  - load LFSR k with seed ((k·SEED_STEP) mod M) + 1;
  - clear the ones counter and the cycle counter.
- RUN: BUSY=1 and the product gate is enabled. Each cycle:
  - bit_k = (R_k ≤ Xreg_k), with R_k ∈ 1..M;
  - gate output = AND of all bit_k;
  - ones counter += gate output;
  - every LFSR steps;
  - cycle counter increments.
- RUN exits after M evaluated cycles, → FINISH.
- FINISH: Y ← ones counter; DONE=1 for this cycle only; BUSY=0; → IDLE.
- Gate enable is low outside RUN, so STREAM=0 whenever not RUN.
- START outside IDLE is ignored; no queuing.
- X changes after the START cycle have no effect on the running window.
- Arithmetic:
  - ones counter is W bits and cannot overflow, because max count = M = 2^W − 1;
  - cycle counter is W bits and terminates at M.
- Exactness:
  - N=1 gives Y = X exactly;
  - any operand 0 gives Y=0;
  - all operands = M gives Y=M.
  - Otherwise Y is an estimate; LFSR correlation from shifted seeds is accepted.
- Reset values: BUSY=0, DONE=0, Y=0, STREAM=0, state IDLE, counters 0, LFSRs at their seeds. Reset mid-RUN discards the partial count; Y returns to 0.
- RST and START in the same cycle: reset wins.

## Timing
- START high in IDLE at edge t: BUSY=1 from t+1 through t+M.
- First gate evaluation occurs in cycle t+1.
- DONE=1 and the new Y are visible in cycle t+M+1; BUSY=0 in that cycle.
- Earliest next accepted START is at edge t+M+2, so the minimum start-to-start spacing is M+2 cycles.
- STREAM lags the gate by one register stage. It carries the product bit of RUN cycle c during cycle c+1, and this stage is not counted separately.
- Y changes only on the FINISH cycle or on reset.

## Structure
- Shared include/package holds:
  - maximal-length LFSR tap masks indexed by W (3..16);
  - state encodings IDLE/RUN/FINISH;
  - the seed function.
- Sub-module sc_lfsr (parameters W and SEED; ports CLK, RST, LOAD, STEP, R) is instantiated N times in a generate loop.
- The product gate is an instance of the existing M_AND with N inputs, EN driven by (state==RUN).
- Comparators, counters and the FSM live in this module.

## Test plan
- Reset, then idle: BUSY=0, DONE=0, Y=0, STREAM=0. START held low for 20 cycles causes no change.
- N=1, W=8, X=100, START pulse: BUSY high 255 cycles, DONE at +256, Y=100.
- N=3, W=8, X={255,255,255}: Y=255. Then X={255,0,255}: Y=0, and STREAM stays 0 throughout.
- N=3, W=8, X={128,128,128}: Y within ±12 of 32. Y is held stable until the next DONE, with X toggled every cycle during RUN.
- START pulses at RUN cycles 1, 100 and 254 are ignored. After DONE, the next START is accepted at DONE+1 cycle, giving a second window with 255 BUSY cycles.
- RST asserted at RUN cycle 50 clears BUSY/Y/STREAM next cycle with no DONE. A fresh START then gives a full 255-cycle window and the correct Y.
